// File: rtl/line_pkg.sv
// Shared coordinate widths, extractor states and line_coord packing.
package line_pkg;

    localparam int unsigned X_W    = 11;
    localparam int unsigned Y_W    = 10;
    localparam int unsigned LINE_W = 84;
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned PAD_W  = LINE_W - 2 * (X_W + Y_W);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        PUBLISH = 2'd2
    } extract_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } point_t;

    // Pack two endpoints into the renderer's 84-bit line format.
    function automatic logic [LINE_W-1:0] pack_line(
        input logic [X_W-1:0] x1,
        input logic [Y_W-1:0] y1,
        input logic [X_W-1:0] x2,
        input logic [Y_W-1:0] y2
    );
        return {x1, y1, x2, y2, {PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/line_extent_tracker.sv
// Tracks leftmost, rightmost, top and bottom masked pixels plus a saturating count.
module line_extent_tracker
    import line_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear,
    input  logic             sample,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    output point_t           left,
    output point_t           right,
    output point_t           top,
    output point_t           bottom,
    output logic [CNT_W-1:0] count
);

    point_t pix;
    logic   seen;

    assign pix.x = x;
    assign pix.y = y;

    // Extreme-point update; strict compares keep the first pixel in raster order on ties.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            left   <= '{x: {X_W{1'b1}}, y: '0};
            right  <= '0;
            top    <= '0;
            bottom <= '0;
            seen   <= 1'b0;
            count  <= '0;
        end else if (clear) begin
            left   <= '{x: {X_W{1'b1}}, y: '0};
            right  <= '0;
            top    <= '0;
            bottom <= '0;
            seen   <= 1'b0;
            count  <= '0;
        end else if (sample) begin
            if (!seen || (x < left.x))  left  <= pix;
            if (!seen || (x > right.x)) right <= pix;
            if (!seen)                  top   <= pix;
            bottom <= pix;
            seen   <= 1'b1;
            if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/line_extractor.sv
// Recovers the two endpoints of the crayon stroke from the per-frame mask stream.
module line_extractor
    import line_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [X_W-1:0]    hcount_in,
    input  logic [Y_W-1:0]    vcount_in,
    input  logic              mask_in,
    output logic [LINE_W-1:0] line_coord,
    output logic              coord_valid,
    output logic              line_found,
    output logic [CNT_W-1:0]  pixel_count
);

    extract_state_t   state, state_next;
    logic             active_c, frame_end_c;
    logic             sample_c, clear_c, publish_c, found_c;
    logic [X_W-1:0]   dx_c;
    logic [Y_W-1:0]   dy_c;
    point_t           left, right, top, bottom;
    point_t           a_c, b_c, p1_c, p2_c;
    logic [CNT_W-1:0] count;

    assign active_c    = (32'(hcount_in) < H_ACTIVE) && (32'(vcount_in) < V_ACTIVE);
    assign frame_end_c = (32'(hcount_in) == H_ACTIVE - 1) && (32'(vcount_in) == V_ACTIVE - 1);

    line_extent_tracker u_tracker (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (clear_c),
        .sample (sample_c),
        .x      (hcount_in),
        .y      (vcount_in),
        .left   (left),
        .right  (right),
        .top    (top),
        .bottom (bottom),
        .count  (count)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ACCUM;
        else        state <= state_next;
    end

    // Next state; outputs are loaded while leaving RESOLVE so they show in the PUBLISH cycle.
    always_comb begin
        state_next = state;
        sample_c   = 1'b0;
        clear_c    = 1'b0;
        publish_c  = 1'b0;
        case (state)
            ACCUM: begin
                sample_c = mask_in && active_c;
                if (frame_end_c) state_next = RESOLVE;
            end
            RESOLVE: begin
                publish_c  = 1'b1;
                state_next = PUBLISH;
            end
            PUBLISH: begin
                clear_c    = 1'b1;
                state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    assign dx_c    = right.x - left.x;
    assign dy_c    = bottom.y - top.y;
    assign found_c = 32'(count) >= MIN_PIXELS;

    // Pick the dominant axis pair, then order it so x1 <= x2 (smaller y first on equal x).
    always_comb begin
        a_c  = left;
        b_c  = right;
        if (X_W'(dy_c) > dx_c) begin
            a_c = top;
            b_c = bottom;
        end
        p1_c = a_c;
        p2_c = b_c;
        if ((a_c.x > b_c.x) || ((a_c.x == b_c.x) && (a_c.y > b_c.y))) begin
            p1_c = b_c;
            p2_c = a_c;
        end
    end

    // Published result registers; line_coord only moves on a valid stroke.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            line_coord  <= '0;
            coord_valid <= 1'b0;
            line_found  <= 1'b0;
            pixel_count <= '0;
        end else begin
            coord_valid <= publish_c;
            if (publish_c) begin
                pixel_count <= count;
                line_found  <= found_c;
                if (found_c) line_coord <= pack_line(p1_c.x, p1_c.y, p2_c.x, p2_c.y);
            end
        end
    end

endmodule

// File: doc/line_extractor.md
# line_extractor

Reverse of the line renderer: watches the camera pixel stream's binary crayon mask and recovers the two endpoints of the drawn stroke once per frame. It packs them into the same 84-bit `line_coord` format the renderer consumes, so a detected stroke can be fed straight back for overlay and physics. It sits after mask thresholding and before the physics/overlay stage, sharing the video clock and counters.

## Interface
Parameters:
- `H_ACTIVE`, default 1280: active pixels per line.
- `V_ACTIVE`, default 720: active lines per frame.
- `MIN_PIXELS`, default 16: minimum masked-pixel count for a valid stroke.

Ports:
- `clk_in`, input, 1: pixel clock.
- `rst_in`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `hcount_in`, input, 11: current pixel x.
- `vcount_in`, input, 10: current pixel y.
- `mask_in`, input, 1: pixel belongs to the crayon stroke.
- `line_coord`, output, 84: `{x1[10:0], y1[9:0], x2[10:0], y2[9:0], 42'b0}` with x1 <= x2.
- `coord_valid`, output, 1: one-cycle pulse when the frame result is published.
- `line_found`, output, 1: last published frame met `MIN_PIXELS`; held until the next publish.
- `pixel_count`, output, 20: masked pixels in the last published frame; saturates at 20'hFFFFF.

## Operation
- Only pixels with hcount < `H_ACTIVE`, vcount < `V_ACTIVE` and state ACCUM are considered.
- States are ACCUM -> RESOLVE -> PUBLISH -> ACCUM.
- **ACCUM.** For each masked active pixel:
  - Left: take it if x < xmin. On equal x, keep the first in raster order, i.e. the smaller y.
  - Right: take it if x > xmax. On equal x, keep the first.
  - Top: the first masked pixel of the frame.
  - Bottom: every masked pixel overwrites it, so it ends as the last in raster order.
  - Count: increment, saturating.
- **Frame end.** Sampling (H_ACTIVE-1, V_ACTIVE-1) processes that pixel, then moves to RESOLVE.
- **RESOLVE.** Compute dx = xmax - xmin and dy = ybot - ytop, both unsigned.
  - If dy > dx, the endpoints are top and bottom.
  - Otherwise (ties included) they are left and right.
  - Order the pair so x1 <= x2. If x1 == x2, put the smaller y first.
- **PUBLISH.**
  - Pulse `coord_valid`, update `pixel_count`, and set `line_found = (count >= MIN_PIXELS)`.
  - `line_coord` is updated only when `line_found` = 1; otherwise it keeps its previous value.
  - Clear all accumulators (xmin = all-ones, xmax = 0, top-seen flag = 0, count = 0) and return to ACCUM.
- A frame with zero masked pixels publishes count 0 and `line_found` = 0.

## Timing
- Reset values: state ACCUM; `line_coord` = 0; `coord_valid` = 0; `line_found` = 0; `pixel_count` = 0; accumulators cleared. Reset takes effect asynchronously, mid-frame included. The partial frame is discarded, and accumulation restarts on the first clock after deassert, without waiting for a frame boundary.
- Accumulator update is registered one cycle after the sampled pixel.
- `coord_valid` is high exactly 2 cycles after the cycle in which the last active pixel was sampled.
- Published outputs are stable from the `coord_valid` cycle until the next publish.
- RESOLVE and PUBLISH fall in horizontal blanking, so no active pixel is lost. Any mask input during those states is ignored.
- A frame-end coordinate seen while not in ACCUM is ignored.
- All comparisons are unsigned. dx is 11 bits and dy is 10 bits; dy is zero-extended for the compare.

## Structure
- Package `line_pkg` holds:
  - the coordinate width constants (X_W = 11, Y_W = 10, LINE_W = 84);
  - the state enum `extract_state_t`;
  - the function `pack_line(x1, y1, x2, y2)` producing the 84-bit format.

  The renderer side imports the same package.
- One sub-module, `line_extent_tracker`, holds the four extreme-point registers and the saturating counter, with a synchronous clear input. `line_extractor` keeps the FSM, the resolve logic and the output registers.

## Test plan
- Horizontal stroke, mask at y = 100, x = 200..400: `coord_valid` 2 cycles after pixel (1279,719); `line_coord` = {200,100,400,100}; `pixel_count` = 201; `line_found` = 1.
- Steep stroke, pixels (500,50)…(510,300), one per row: dy (250) > dx (10) selects top/bottom; result {500,50,510,300}.
- Anti-diagonal (600,100)->(300,400), one pixel per row: dx = dy = 300 selects left/right; result {300,400,600,100}, with x1 <= x2 swap verified.
- 10-pixel blob with `MIN_PIXELS` = 16, after a valid frame: `line_found` = 0, `pixel_count` = 10, `line_coord` unchanged from the prior frame.
- Reset asserted at row 360 of a stroke frame, released at row 361: outputs read zero during reset. The next publish reflects only rows 361..719, and the following frame is the full stroke.
- Mask asserted at hcount = 1300 (blanking) only: `pixel_count` = 0 and `line_found` = 0.
